// File: rtl/cpu_pkg.sv
// Commit trace record layout shared by the core observation port and the trace buffer.
// Latency: none (types and constants only).
// Backpressure: n/a. Timestamp field exists only under COMMIT_TRACE_TIMESTAMP_EN.
package cpu_pkg;

   localparam int TRACE_TS_W = 32;

   // One retired instruction, MSB first: pc, instr, rd_we, rd, rd_data[, ts].
   typedef struct packed {
      logic [15:0]           pc;
      logic [15:0]           instr;
      logic                  rd_we;
      logic [2:0]            rd;
      logic [15:0]           rd_data;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
      logic [TRACE_TS_W-1:0] ts;
`endif
   } trace_entry_t;

   localparam int TRACE_W = $bits(trace_entry_t);

endpackage

// File: rtl/trace_fifo.sv
// Generic show-ahead synchronous FIFO (register array, wrapping pointers, occupancy count).
// Latency: a word pushed in cycle N appears at pop_dat in cycle N+1; no empty bypass.
// Backpressure: push while full is ignored unless a pop happens in the same cycle; clr wins.
module trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    cnt;
   logic             wr_en;
   logic             rd_en;

   // A full FIFO still takes a push when the head leaves in the same cycle.
   always_comb begin
      rd_en = pop && !empty;
      wr_en = push && (!full || rd_en);
   end

   // Pointers and occupancy; clr empties the FIFO without touching storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage is cleared on reset so the head reads zero; each slot is written once per residency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en && !clr) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   assign pop_dat = mem[rd_ptr];
   assign full    = (cnt == LW'(DEPTH));
   assign empty   = (cnt == '0);
   assign level   = cnt;

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures per-instruction commit records into a FIFO and drains them to a trace sink.
// Latency: commit in cycle N is visible on trace_entry in cycle N+1 (show-ahead, no bypass).
// Backpressure: never stalls the core; records arriving to a full FIFO without a pop are
// dropped and counted. Define COMMIT_TRACE_TIMESTAMP_EN to append a 32-bit cycle stamp.
module commit_trace_buffer
   import cpu_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DROP_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    trace_en,
   input  logic                    flush,
   input  logic                    commit_valid,
   input  logic [15:0]             commit_pc,
   input  logic [15:0]             commit_instr,
   input  logic                    commit_rd_we,
   input  logic [2:0]              commit_rd,
   input  logic [15:0]             commit_rd_data,
   output logic                    trace_valid,
   input  logic                    trace_ready,
   output logic [TRACE_W-1:0]      trace_entry,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    overflow,
   output logic [DROP_W-1:0]       drop_count
);

   trace_entry_t wr_entry;
   logic         fifo_full;
   logic         fifo_empty;
   logic         capture;
   logic         fifo_push;
   logic         fifo_pop;
   logic         drop;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
   logic [TRACE_TS_W-1:0] ts_cnt;

   // Free-running cycle stamp; flush restarts it so stamps are relative to the last clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     ts_cnt <= '0;
      else if (flush) ts_cnt <= '0;
      else            ts_cnt <= ts_cnt + 32'd1;
   end
`endif

   // Pack the commit record; the stamp is the counter value during the push cycle.
   always_comb begin
      wr_entry         = '0;
      wr_entry.pc      = commit_pc;
      wr_entry.instr   = commit_instr;
      wr_entry.rd_we   = commit_rd_we;
      wr_entry.rd      = commit_rd;
      wr_entry.rd_data = commit_rd_data;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
      wr_entry.ts      = ts_cnt;
`endif
   end

   // Push/pop/drop decode; flush discards everything happening in its cycle.
   always_comb begin
      capture   = commit_valid && trace_en;
      fifo_pop  = trace_valid && trace_ready && !flush;
      fifo_push = capture && !flush;
      drop      = fifo_push && fifo_full && !fifo_pop;
   end

   trace_fifo #(
      .WIDTH (TRACE_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (flush),
      .push     (fifo_push),
      .push_dat (wr_entry),
      .pop      (fifo_pop),
      .pop_dat  (trace_entry),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (level)
   );

   assign trace_valid = !fifo_empty;

   // Drop accounting: sticky overflow flag and a counter that saturates at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (flush) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_count != {DROP_W{1'b1}}) drop_count <= drop_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;
   import cpu_pkg::*;

   localparam int DEPTH  = 16;
   localparam int DROP_W = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              trace_en;
   logic              flush;
   logic              commit_valid;
   logic [15:0]       commit_pc;
   logic [15:0]       commit_instr;
   logic              commit_rd_we;
   logic [2:0]        commit_rd;
   logic [15:0]       commit_rd_data;
   logic              trace_valid;
   logic              trace_ready;
   logic [TRACE_W-1:0] trace_entry;
   logic [4:0]        level;
   logic              overflow;
   logic [DROP_W-1:0] drop_count;

   commit_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
      .clk(clk), .rst_n(rst_n), .trace_en(trace_en), .flush(flush),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
      .commit_rd_we(commit_rd_we), .commit_rd(commit_rd), .commit_rd_data(commit_rd_data),
      .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_entry(trace_entry),
      .level(level), .overflow(overflow), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   // Scoreboard and reference model state.
   trace_entry_t sb[$];
   logic [DROP_W-1:0] m_drop;
   logic              m_ovf;
   logic [31:0]       m_ts;
   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] instr;
      logic        we;
      logic [2:0]  rd;
      logic [15:0] data;
      logic        ready;
      logic [4:0]  exp_level;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic trace_entry_t mk(input logic [15:0] pc, input logic [15:0] instr,
                                       input logic we, input logic [2:0] rd, input logic [15:0] d);
      trace_entry_t e;
      e = '0;
      e.pc = pc; e.instr = instr; e.rd_we = we; e.rd = rd; e.rd_data = d;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
      e.ts = m_ts;
`endif
      return e;
   endfunction

   task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] instr,
                        input logic we, input logic [2:0] rd, input logic [15:0] d);
      commit_valid = v; commit_pc = pc; commit_instr = instr;
      commit_rd_we = we; commit_rd = rd; commit_rd_data = d;
   endtask

   // One clock: model the cycle from current inputs, compare pops, step, compare state.
   task automatic tick();
      trace_entry_t e;
      bit pop_m;
      pop_m = (sb.size() != 0) && trace_ready;
      chk("valid", trace_valid, sb.size() != 0);
      if (flush) begin
         sb.delete();
         m_drop = '0;
         m_ovf  = 1'b0;
      end else begin
         if (pop_m) begin
            e = sb.pop_front();
            chk("pop_entry", trace_entry, e);
         end
         if (commit_valid && trace_en) begin
            if (sb.size() < DEPTH) begin
               sb.push_back(mk(commit_pc, commit_instr, commit_rd_we, commit_rd, commit_rd_data));
            end else begin
               m_ovf = 1'b1;
               if (m_drop != 4'hF) m_drop = m_drop + 1'b1;
            end
         end
      end
      @(posedge clk); #1;
      m_ts = flush ? 32'd0 : m_ts + 32'd1;
      chk("level", level, sb.size());
      chk("drop_count", drop_count, m_drop);
      chk("overflow", overflow, m_ovf);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      trace_entry_t exp_e;
      vecs[0] = '{16'h0010, 16'hA5A5, 1'b1, 3'd3, 16'h1234, 1'b1, 5'd1};
      vecs[1] = '{16'h0020, 16'h1111, 1'b0, 3'd0, 16'hFFFF, 1'b0, 5'd2};
      vecs[2] = '{16'h0030, 16'h2222, 1'b1, 3'd7, 16'h0001, 1'b1, 5'd2};
      vecs[3] = '{16'h0040, 16'h3333, 1'b1, 3'd5, 16'h8000, 1'b1, 5'd2};
      vecs[4] = '{16'h0050, 16'h4444, 1'b0, 3'd2, 16'h5A5A, 1'b0, 5'd3};
      vecs[5] = '{16'h0060, 16'h5555, 1'b1, 3'd1, 16'hC3C3, 1'b1, 5'd3};

      rst_n = 1'b0; trace_en = 1'b1; flush = 1'b0; trace_ready = 1'b0;
      drive(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
      m_drop = '0; m_ovf = 1'b0; m_ts = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", trace_valid, 1'b0);
      chk("rst_entry", trace_entry, 0);
      chk("rst_level", level, 0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_drop", drop_count, 0);
      rst_n = 1'b1;

      // Table: mixed push/pop patterns with expected occupancy.
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, vecs[i].pc, vecs[i].instr, vecs[i].we, vecs[i].rd, vecs[i].data);
         trace_ready = vecs[i].ready;
         exp_e = mk(vecs[i].pc, vecs[i].instr, vecs[i].we, vecs[i].rd, vecs[i].data);
         tick();
         chk("vec_level", level, vecs[i].exp_level);
         if (i == 0) begin
            chk("first_valid", trace_valid, 1'b1);
            chk("first_entry", trace_entry, exp_e);
         end
      end
      drive(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
      trace_ready = 1'b1;
      repeat (4) tick();
      chk("drain_level", level, 0);

      // Overfill: 20 commits into 16 entries with the sink stalled.
      trace_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 16'h0100 + 16'(i), 16'hBEEF, 1'b1, 3'(i), 16'(i * 3));
         tick();
      end
      chk("full_level", level, 16);
      chk("full_drop", drop_count, 4);
      chk("full_ovf", overflow, 1'b1);

      // Full FIFO with a simultaneous pop accepts the commit.
      trace_ready = 1'b1;
      drive(1'b1, 16'h0200, 16'h7777, 1'b0, 3'd4, 16'h0042);
      tick();
      chk("full_pop_level", level, 16);
      chk("full_pop_drop", drop_count, 4);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
      repeat (16) tick();
      chk("drain2_level", level, 0);

      // Sink stall with 3 entries: head must hold.
      trace_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'h0400 + 16'(i), 16'h4321, 1'b1, 3'd6, 16'(i));
         tick();
      end
      drive(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_entry", trace_entry, sb[0]);
         chk("hold_valid", trace_valid, 1'b1);
      end
      trace_ready = 1'b1;
      repeat (3) tick();

      // Drop counter saturation.
      trace_ready = 1'b0;
      for (int i = 0; i < 36; i++) begin
         drive(1'b1, 16'h0300 + 16'(i), 16'h9999, 1'b0, 3'd0, 16'(i));
         tick();
      end
      chk("sat_drop", drop_count, 4'hF);
      chk("sat_level", level, 16);

      // trace_en low: commits ignored, buffered entries keep draining.
      trace_en = 1'b0; trace_ready = 1'b1;
      repeat (9) tick();
      chk("den_level", level, 7);
      chk("den_drop", drop_count, 4'hF);

      // Flush with a colliding commit and pop.
      trace_en = 1'b1; flush = 1'b1;
      drive(1'b1, 16'h0666, 16'h6666, 1'b1, 3'd6, 16'h6666);
      tick();
      flush = 1'b0;
      drive(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
      chk("flush_level", level, 0);
      chk("flush_valid", trace_valid, 1'b0);
      chk("flush_drop", drop_count, 0);
      chk("flush_ovf", overflow, 1'b0);

      // Reset in the middle of a drain.
      trace_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 16'h0700 + 16'(i), 16'h0F0F, 1'b1, 3'd2, 16'(i));
         tick();
      end
      drive(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
      trace_ready = 1'b1;
      tick();
      rst_n = 1'b0;
      #1;
      chk("arst_valid", trace_valid, 1'b0);
      chk("arst_level", level, 0);
      sb.delete(); m_drop = '0; m_ovf = 1'b0; m_ts = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Timestamps: commits in cycles 5 and 9 after reset.
      trace_ready = 1'b0;
      repeat (5) tick();
      drive(1'b1, 16'h0500, 16'h0005, 1'b0, 3'd0, 16'h0005);
      tick();
      drive(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
      repeat (3) tick();
      drive(1'b1, 16'h0900, 16'h0009, 1'b0, 3'd0, 16'h0009);
      tick();
      drive(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
`ifdef COMMIT_TRACE_TIMESTAMP_EN
      exp_e = trace_entry_t'(trace_entry);
      chk("ts_first", exp_e.ts, 32'd5);
`endif
      trace_ready = 1'b1;
      tick();
`ifdef COMMIT_TRACE_TIMESTAMP_EN
      exp_e = trace_entry_t'(trace_entry);
      chk("ts_second", exp_e.ts, 32'd9);
`endif
      repeat (2) tick();
      chk("final_level", level, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
